// File: rtl/inert_pkg.sv
// Shared register map and frame-phase encoding for the inertial sensor responder.
package inert_pkg;

  localparam logic [6:0] ADDR_INT_CTRL = 7'h0D;
  localparam logic [6:0] ADDR_WHOAMI   = 7'h0F;
  localparam logic [6:0] ADDR_CFG_A    = 7'h10;
  localparam logic [6:0] ADDR_CFG_G    = 7'h11;
  localparam logic [6:0] ADDR_CFG_C    = 7'h14;
  localparam logic [6:0] ADDR_STATUS   = 7'h1E;
  localparam logic [6:0] ADDR_PTCHL    = 7'h22;
  localparam logic [6:0] ADDR_PTCHH    = 7'h23;
  localparam logic [6:0] ADDR_AZL      = 7'h2C;
  localparam logic [6:0] ADDR_AZH      = 7'h2D;

  typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} frm_phase_t;

endpackage

// File: rtl/spi_serf_shft.sv
// SPI serial front end: pin synchronizers, edge detect, bit counting and rx/tx shifters.
module spi_serf_shft
  import inert_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        SS_n,
  input  logic        SCLK,
  input  logic        MOSI,
  input  logic [7:0]  tx_byte,
  output logic        MISO,
  output logic        addr_vld,
  output logic        frm_done,
  output logic [15:0] rx_word
);

  logic [2:0] ss_s;
  logic [2:0] sclk_s;
  logic [1:0] mosi_s;
  logic [4:0] bit_cnt;
  logic [7:0] tx_shft;
  frm_phase_t phase;

  logic rise, fall, ss_fall;
  assign rise    = sclk_s[1] & ~sclk_s[2];
  assign fall    = ~sclk_s[1] & sclk_s[2];
  assign ss_fall = ~ss_s[1] & ss_s[2];

  // SS sync resets low so a reset taken mid-frame cannot fake a select fall.
  always_ff @(posedge clk) begin
    if (rst) begin
      ss_s     <= '0;
      sclk_s   <= '1;
      mosi_s   <= '0;
      bit_cnt  <= '0;
      rx_word  <= '0;
      tx_shft  <= '0;
      MISO     <= 1'b0;
      addr_vld <= 1'b0;
      frm_done <= 1'b0;
      phase    <= IDLE;
    end else begin
      ss_s     <= {ss_s[1:0], SS_n};
      sclk_s   <= {sclk_s[1:0], SCLK};
      mosi_s   <= {mosi_s[0], MOSI};
      addr_vld <= 1'b0;
      frm_done <= 1'b0;
      if (ss_s[1]) begin
        phase <= IDLE;
        MISO  <= 1'b0;
      end else begin
        case (phase)
          IDLE: if (ss_fall) begin
            phase   <= CMD;
            bit_cnt <= '0;
            tx_shft <= '0;
            MISO    <= 1'b0;
          end
          CMD: if (rise) begin
            rx_word <= {rx_word[14:0], mosi_s[1]};
            bit_cnt <= bit_cnt + 5'd1;
            if (bit_cnt == 5'd7) begin
              phase    <= DATA;
              addr_vld <= 1'b1;
            end
          end
          DATA: begin
            // tx_byte is decoded from the command byte now sitting in rx_word[7:0].
            if (addr_vld) tx_shft <= tx_byte;
            if (fall) begin
              MISO    <= tx_shft[7];
              tx_shft <= {tx_shft[6:0], 1'b0};
            end
            if (rise) begin
              rx_word <= {rx_word[14:0], mosi_s[1]};
              bit_cnt <= bit_cnt + 5'd1;
              if (bit_cnt == 5'd15) begin
                phase    <= DONE;
                frm_done <= 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/inert_sensor_resp.sv
// Inertial sensor SPI responder: register file, sample capture, INT/overrun handling and read mux.
module inert_sensor_resp
  import inert_pkg::*;
#(
  parameter logic [7:0]  WHOAMI     = 8'h6A,
  parameter int unsigned INT_EN_BIT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        SS_n,
  input  logic        SCLK,
  input  logic        MOSI,
  output logic        MISO,
  output logic        INT,
  input  logic        smpl,
  input  logic [15:0] ptch_rt_in,
  input  logic [15:0] AZ_in,
  output logic        ovr
);

  logic [15:0] rx_word;
  logic        addr_vld, frm_done;
  logic [7:0]  tx_byte;
  logic [7:0]  int_ctrl, cfg_a, cfg_g, cfg_c;
  logic [15:0] ptch, az;

  spi_serf_shft u_shft (
    .clk      (clk),
    .rst      (rst),
    .SS_n     (SS_n),
    .SCLK     (SCLK),
    .MOSI     (MOSI),
    .tx_byte  (tx_byte),
    .MISO     (MISO),
    .addr_vld (addr_vld),
    .frm_done (frm_done),
    .rx_word  (rx_word)
  );

  // Read mux works on the command byte alone, valid from the 8th rise onward.
  always_comb begin
    tx_byte = '0;
    if (rx_word[7]) begin
      case (rx_word[6:0])
        ADDR_INT_CTRL: tx_byte = int_ctrl;
        ADDR_WHOAMI:   tx_byte = WHOAMI;
        ADDR_CFG_A:    tx_byte = cfg_a;
        ADDR_CFG_G:    tx_byte = cfg_g;
        ADDR_CFG_C:    tx_byte = cfg_c;
        ADDR_STATUS:   tx_byte = {6'b0, ovr, INT};
        ADDR_PTCHL:    tx_byte = ptch[7:0];
        ADDR_PTCHH:    tx_byte = ptch[15:8];
        ADDR_AZL:      tx_byte = az[7:0];
        ADDR_AZH:      tx_byte = az[15:8];
        default:       tx_byte = '0;
      endcase
    end
  end

  logic       rd, wr, int_clr, int_busy;
  logic [6:0] addr;
  logic [7:0] wdat;
  assign rd       = frm_done & rx_word[15];
  assign wr       = frm_done & ~rx_word[15];
  assign addr     = rx_word[14:8];
  assign wdat     = rx_word[7:0];
  assign int_clr  = rd && (addr == ADDR_AZH);
  assign int_busy = INT & ~int_clr;

  // Later assignments win: smpl set of INT/ovr overrides the read-side clears.
  always_ff @(posedge clk) begin
    if (rst) begin
      int_ctrl <= '0;
      cfg_a    <= '0;
      cfg_g    <= '0;
      cfg_c    <= '0;
      ptch     <= '0;
      az       <= '0;
      INT      <= 1'b0;
      ovr      <= 1'b0;
    end else begin
      if (wr) begin
        case (addr)
          ADDR_INT_CTRL: begin
            int_ctrl <= wdat;
            if (!wdat[INT_EN_BIT]) INT <= 1'b0;
          end
          ADDR_CFG_A: cfg_a <= wdat;
          ADDR_CFG_G: cfg_g <= wdat;
          ADDR_CFG_C: cfg_c <= wdat;
          default: ;
        endcase
      end
      if (int_clr) INT <= 1'b0;
      if (rd && (addr == ADDR_STATUS)) ovr <= 1'b0;
      if (smpl) begin
        if (!int_busy) begin
          ptch <= ptch_rt_in;
          az   <= AZ_in;
          if (int_ctrl[INT_EN_BIT]) INT <= 1'b1;
        end else begin
          ovr <= 1'b1;
        end
      end
    end
  end

endmodule
